// File: rtl/latch_close_capture.sv
// latch_close_capture
//   Capture stage that sits right after a level-sensitive latch bank. Each
//   close of the latch (enable falling 1->0) records the held value into a
//   small FIFO. The FIFO is drained over valid/ready. Captures lost to a full
//   FIFO are counted. Any movement of the latch output while it should be
//   holding raises a sticky error flag.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   lat_en            upstream latch enable (1 = transparent)
//   lat_clr           upstream latch clear (1 forces latch output to 0)
//   lat_q             upstream latch output
//   out_valid         FIFO non-empty
//   out_ready         consumer accepts head entry
//   out_data          FIFO head entry (valid only with out_valid)
//   level             FIFO occupancy
//   drop_cnt          captures lost to a full FIFO, saturating at 255
//   hold_err          sticky: latch output changed while holding
module latch_close_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lat_en,
    input  logic                       lat_clr,
    input  logic [WIDTH-1:0]           lat_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 drop_cnt,
    output logic                       hold_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic             en_q;
    logic [WIDTH-1:0] q_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             close_evt;
    logic [WIDTH-1:0] cap_val;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             hold_viol;

    assign close_evt = en_q & ~lat_en;
    assign cap_val   = lat_clr ? '0 : lat_q;
    assign full      = (level == FULL_LVL);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = close_evt & (~full | pop);
    assign drop      = close_evt & full & ~pop;
    // en_q=0 excludes the close cycle itself; clear legitimately moves lat_q.
    assign hold_viol = ~en_q & ~lat_en & ~lat_clr & (lat_q != q_q);

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            q_q      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            hold_err <= 1'b0;
        end else begin
            en_q <= lat_en;
            q_q  <= lat_q;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (hold_viol)
                hold_err <= 1'b1;
        end
    end

    // Storage carries no reset; entries are only observable once pushed.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= cap_val;
    end
endmodule

// File: tb/tb_latch_close_capture.sv
// tb_latch_close_capture
//   Self-checking bench for latch_close_capture (WIDTH=4, DEPTH=4). Inputs are
//   driven and outputs sampled at the falling edge; the rising edge in between
//   is the active edge. Expected captures go into a scoreboard queue when a
//   close is driven and are popped/compared when the DUT presents them.
module tb_latch_close_capture;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             lat_en;
    logic             lat_clr;
    logic [WIDTH-1:0] lat_q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       level;
    logic [7:0]       drop_cnt;
    logic             hold_err;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_drop = 0;
    logic             exp_hold = 1'b0;

    latch_close_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .lat_en(lat_en), .lat_clr(lat_clr), .lat_q(lat_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .drop_cnt(drop_cnt), .hold_err(hold_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Open the latch with a new value for one cycle, then close it. The close
    // edge happens at the next rising edge; returns at the falling edge after.
    task automatic close_evt(input logic [WIDTH-1:0] v, input logic clr);
        lat_en = 1'b1; lat_q = v; lat_clr = 1'b0;
        tick();
        lat_en = 1'b0; lat_clr = clr;
        if (exp_q.size() < DEPTH) exp_q.push_back(clr ? 4'h0 : v);
        else if (exp_drop < 255) exp_drop++;
        tick();
        lat_clr = 1'b0;
    endtask

    task automatic pop_chk(input string nm);
        logic [WIDTH-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s: model queue empty, out_valid=%0b", nm, out_valid);
        end else begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL %s: got valid=%0b data=%0h, expected valid=1 data=%0h", nm, out_valid, out_data, e);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_status(input string nm);
        checks++;
        if (level !== 3'(exp_q.size()) || drop_cnt !== 8'(exp_drop) || hold_err !== exp_hold ||
            out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL %s: got level=%0d drop=%0d hold=%0b valid=%0b, expected level=%0d drop=%0d hold=%0b",
                     nm, level, drop_cnt, hold_err, out_valid, exp_q.size(), exp_drop, exp_hold);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lat_en = 1'b0; lat_clr = 1'b0; lat_q = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 8'd0 || hold_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got valid=%0b level=%0d drop=%0d hold=%0b, expected all 0",
                     out_valid, level, drop_cnt, hold_err);
        end
        // lat_en held low out of reset must not produce a capture
        tick();
        chk_status("reset_no_close");
    endtask

    task automatic test_single();
        close_evt(4'hA, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || level !== 3'd1) begin
            errors++;
            $display("FAIL single_latency: got valid=%0b data=%0h level=%0d, expected 1 a 1", out_valid, out_data, level);
        end
        tick();
        checks++;
        if (out_data !== 4'hA || out_valid !== 1'b1) begin
            errors++; $display("FAIL single_stable: got data=%0h valid=%0b, expected a 1", out_data, out_valid);
        end
        pop_chk("single_pop");
        chk_status("single_empty");
    endtask

    task automatic test_clear();
        close_evt(4'h5, 1'b1);
        tick();
        chk_status("clear_status");
        pop_chk("clear_value");
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 6; v++) close_evt(4'(v), 1'b0);
        chk_status("ovf_full");
        checks++;
        if (level !== 3'd4 || drop_cnt !== 8'd2) begin
            errors++; $display("FAIL ovf_counts: got level=%0d drop=%0d, expected 4 2", level, drop_cnt);
        end
        for (int i = 0; i < 4; i++) pop_chk("ovf_drain");
        chk_status("ovf_empty");
        for (int v = 7; v <= 10; v++) close_evt(4'(v), 1'b0);
        // close while full with a pop in the same cycle: accepted, no drop
        lat_en = 1'b1; lat_q = 4'hB;
        tick();
        lat_en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            errors++; $display("FAIL ovf_pp_head: got data=%0h, expected %0h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(4'hB);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_status("ovf_push_pop");
        for (int i = 0; i < 4; i++) pop_chk("ovf_pp_drain");
    endtask

    task automatic test_open();
        lat_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lat_q = 4'(i * 3 + 1);
            tick();
        end
        chk_status("open_no_push");
        lat_q = 4'h3;
        tick();
        lat_en = 1'b0;
        exp_q.push_back(4'h3);
        tick();
        chk_status("open_then_close");
        pop_chk("open_value");
    endtask

    task automatic test_hold();
        close_evt(4'h3, 1'b0);
        tick();
        chk_status("hold_before");
        lat_q = 4'h7;
        exp_hold = 1'b1;
        tick();
        chk_status("hold_set");
        lat_q = 4'h3;
        tick(); tick();
        chk_status("hold_sticky");
        pop_chk("hold_value");
    endtask

    task automatic test_reset_mid();
        for (int v = 1; v <= 7; v++) close_evt(4'(v), 1'b0);
        pop_chk("mid_pop");
        chk_status("mid_pre");
        checks++;
        if (level !== 3'd3 || drop_cnt !== 8'd5 || hold_err !== 1'b1) begin
            errors++; $display("FAIL mid_pre_vals: got level=%0d drop=%0d hold=%0b, expected 3 5 1", level, drop_cnt, hold_err);
        end
        lat_en = 1'b1; lat_q = 4'h0;
        tick();
        // close coincident with reset must be ignored
        rst = 1'b1; lat_en = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete(); exp_drop = 0; exp_hold = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 8'd0 || hold_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b level=%0d drop=%0d hold=%0b, expected all 0",
                     out_valid, level, drop_cnt, hold_err);
        end
        tick();
        chk_status("mid_after");
        close_evt(4'hC, 1'b0);
        checks++;
        if (out_data !== 4'hC || level !== 3'd1) begin
            errors++; $display("FAIL mid_recap: got data=%0h level=%0d, expected c 1", out_data, level);
        end
        pop_chk("mid_pop_c");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4 + 300; i++) close_evt(4'($urandom_range(0, 15)), 1'b0);
        chk_status("sat_status");
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_drop: got %0d, expected 255", drop_cnt);
        end
        for (int i = 0; i < 4; i++) pop_chk("sat_drain");
        chk_status("sat_empty");
    endtask

    initial begin
        test_reset();
        test_single();
        test_clear();
        test_overflow();
        test_open();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
